set_bit_scanner: RTL and testbench

- Consumer-side counterpart to the lowest-set-bit capture register.
- Loads a 10-bit switch word on a button pulse, then drains it one set bit per step pulse, lowest bit first.
- For each bit it presents the isolated one-hot value, its binary index and a running count.
- Sits between the debounced button pulse generators and the LED/7-segment display path.

---
 rtl/set_bit_scanner.sv | 114 +++++++++++
 tb/tb_set_bit_scanner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/set_bit_scanner.sv
// set_bit_scanner: loads a switch word and drains it one set bit per step,
// lowest bit first, presenting the isolated bit, its index and a running count.
//
// Ports:
//   clk_i     system clock, all state changes on the rising edge
//   rstn_i    asynchronous active-low reset
//   data_i    word to scan, sampled only when load_i is high
//   load_i    single-cycle pulse: load data_i (wins over step_i)
//   step_i    single-cycle pulse: consume the current lowest set bit
//   onehot_o  isolated lowest set bit of the remaining word (0 unless ACTIVE)
//   index_o   bit position of onehot_o (0 unless ACTIVE)
//   valid_o   high while ACTIVE
//   done_o    high while DONE (word fully drained)
//   count_o   number of bits consumed since the last load
module set_bit_scanner #(
    parameter int WIDTH = 10,
    parameter int IDX_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             load_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IDX_W-1:0] index_o,
    output logic             valid_o,
    output logic             done_o,
    output logic [CNT_W-1:0] count_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] rem_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [WIDTH-1:0] rem_neg;
    logic [WIDTH-1:0] lowest;
    logic [WIDTH-1:0] rem_clr;
    logic [IDX_W-1:0] lowest_idx;
    logic             active;

    // Two's-complement negate: AND with the original leaves only the
    // lowest set bit. rem & (rem - 1) is the same word with that bit cleared.
    assign rem_neg = ~rem_q + {{(WIDTH-1){1'b0}}, 1'b1};
    assign lowest  = rem_q & rem_neg;
    assign rem_clr = rem_q & (rem_q - {{(WIDTH-1){1'b0}}, 1'b1});

    // lowest is one-hot (or zero), so OR-ing the indices of set bits
    // yields the position without needing priority ordering.
    always_comb begin
        lowest_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (lowest[i]) begin
                lowest_idx = lowest_idx | IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            rem_d   = data_i;
            cnt_d   = '0;
            state_d = (data_i != '0) ? S_ACTIVE : S_DONE;
        end else begin
            unique case (state_q)
                S_ACTIVE: begin
                    if (step_i) begin
                        rem_d   = rem_clr;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = (rem_clr == '0) ? S_DONE : S_ACTIVE;
                    end
                end
                S_IDLE, S_DONE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign active   = (state_q == S_ACTIVE);
    assign onehot_o = active ? lowest : '0;
    assign index_o  = active ? lowest_idx : '0;
    assign valid_o  = active;
    assign done_o   = (state_q == S_DONE);
    assign count_o  = cnt_q;

endmodule

// File: tb/tb_set_bit_scanner.sv
// tb_set_bit_scanner: scoreboard bench for set_bit_scanner.
// Expected outputs come from a list-of-set-bit-positions model.
module tb_set_bit_scanner;

    logic       clk_i;
    logic       rstn_i;
    logic [9:0] data_i;
    logic       load_i;
    logic       step_i;
    logic [9:0] onehot_o;
    logic [3:0] index_o;
    logic       valid_o;
    logic       done_o;
    logic [3:0] count_o;

    set_bit_scanner #(.WIDTH(10), .IDX_W(4), .CNT_W(4)) dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .data_i   (data_i),
        .load_i   (load_i),
        .step_i   (step_i),
        .onehot_o (onehot_o),
        .index_o  (index_o),
        .valid_o  (valid_o),
        .done_o   (done_o),
        .count_o  (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [9:0] oh;
        logic [3:0] idx;
        logic       v;
        logic       d;
        logic [3:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;

    // Model: positions of bits still to be consumed, ascending.
    int   bits[$];
    int   m_cnt;
    int   m_st;   // 0 idle, 1 active, 2 done

    function automatic void m_reset();
        bits.delete();
        m_cnt = 0;
        m_st  = 0;
    endfunction

    function automatic void m_edge(input logic ld, input logic st,
                                   input logic [9:0] d);
        if (!rstn_i) begin
            m_reset();
        end else if (ld) begin
            bits.delete();
            for (int i = 0; i < 10; i++)
                if (d[i]) bits.push_back(i);
            m_cnt = 0;
            m_st  = (bits.size() > 0) ? 1 : 2;
        end else if (st && m_st == 1) begin
            void'(bits.pop_front());
            m_cnt++;
            if (bits.size() == 0) m_st = 2;
        end
    endfunction

    function automatic void push_exp();
        exp_t x;
        x.oh  = '0;
        x.idx = '0;
        x.v   = (m_st == 1);
        x.d   = (m_st == 2);
        x.cnt = 4'(m_cnt);
        if (m_st == 1) begin
            x.oh  = 10'd1 << bits[0];
            x.idx = 4'(bits[0]);
        end
        q.push_back(x);
    endfunction

    task automatic cyc(input logic ld, input logic st, input logic [9:0] d);
        @(negedge clk_i);
        load_i = ld;
        step_i = st;
        data_i = d;
        @(posedge clk_i);
        #1;
        m_edge(ld, st, d);
        push_exp();
        load_i = 1'b0;
        step_i = 1'b0;
        data_i = 10'($urandom);
    endtask

    // Reset between edges: the snapshot of the last edge is superseded
    // before the monitor samples, so replace it with the reset value.
    task automatic async_reset();
        #2;
        rstn_i = 1'b0;
        m_reset();
        if (q.size() > 0) void'(q.pop_back());
        push_exp();
        #4;
        rstn_i = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk_i);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (onehot_o !== e.oh || index_o !== e.idx ||
                    valid_o !== e.v || done_o !== e.d ||
                    count_o !== e.cnt) begin
                    failures++;
                    $display("FAIL scan t=%0t got oh=%h idx=%0d v=%b d=%b cnt=%0d exp oh=%h idx=%0d v=%b d=%b cnt=%0d",
                             $time, onehot_o, index_o, valid_o, done_o,
                             count_o, e.oh, e.idx, e.v, e.d, e.cnt);
                end
            end
        end
    end

    initial begin
        rstn_i = 1'b0;
        load_i = 1'b0;
        step_i = 1'b0;
        data_i = '0;
        m_reset();

        // Reset held while inputs toggle
        for (int i = 0; i < 4; i++)
            cyc(1'($urandom), 1'($urandom), 10'($urandom));
        rstn_i = 1'b1;
        cyc(1'b0, 1'b1, 10'h3ff);
        cyc(1'b0, 1'b0, 10'h000);

        // Drain 0x268, then an extra step in DONE
        cyc(1'b1, 1'b0, 10'h268);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 10'($urandom));

        // Load zero
        cyc(1'b1, 1'b0, 10'h000);
        cyc(1'b0, 1'b1, 10'h000);

        // Load and step together: load wins
        cyc(1'b1, 1'b0, 10'h268);
        cyc(1'b0, 1'b1, 10'h000);
        cyc(1'b1, 1'b1, 10'h300);
        cyc(1'b0, 1'b1, 10'h000);
        cyc(1'b0, 1'b1, 10'h000);
        cyc(1'b0, 1'b0, 10'h000);

        // Full word, back-to-back then spaced steps
        cyc(1'b1, 1'b0, 10'h3ff);
        for (int i = 0; i < 11; i++) cyc(1'b0, 1'b1, 10'($urandom));
        cyc(1'b1, 1'b0, 10'h3ff);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 10'($urandom));
            cyc(1'b0, 1'b0, 10'($urandom));
            cyc(1'b0, 1'b0, 10'($urandom));
        end

        // Async reset mid-drain
        cyc(1'b1, 1'b0, 10'h3ff);
        cyc(1'b0, 1'b1, 10'h000);
        cyc(1'b0, 1'b1, 10'h000);
        async_reset();
        cyc(1'b0, 1'b1, 10'h3ff);
        cyc(1'b1, 1'b0, 10'h001);
        cyc(1'b0, 1'b0, 10'h000);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic [9:0] d;
            d = 10'($urandom);
            if ($urandom_range(0, 7) == 0) d = '0;
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, d);
            if ($urandom_range(0, 40) == 0) async_reset();
        end

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk_i);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
